// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready handshaking,
// detect-only mode and saturating single/double error counters.
module hamming_secded_dec_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16,
    localparam int R = (DATA_W <= 1)  ? 2 :
                       (DATA_W <= 4)  ? 3 :
                       (DATA_W <= 11) ? 4 :
                       (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + R
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_parity,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_err_1bit,
    output logic              out_err_2bit,
    output logic              out_err_parity,
    output logic [CNT_W-1:0]  cnt_1bit,
    output logic [CNT_W-1:0]  cnt_2bit,
    input  logic              cnt_clear
);

    // Syndrome bit k covers every code position whose 1-based index has bit k set.
    function automatic logic [CODE_W-1:0] syn_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int p = 1; p <= CODE_W; p++)
            if (((p >> k) & 1) != 0) m = m | (CODE_W'(1) << (p - 1));
        return m;
    endfunction

    function automatic int data_pos(input int d);
        int res;
        int cnt;
        res = 0;
        cnt = 0;
        for (int p = 1; p <= CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) res = p;
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

    logic [R-1:0]      syn_in;
    logic              par_in;

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s1_cen_q, s1_cen_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [R-1:0]      out_syn_q, out_syn_d;
    logic              err1_q, err1_d;
    logic              err2_q, err2_d;
    logic              errp_q, errp_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic [CNT_W-1:0]  cnt2_q, cnt2_d;

    logic              syn_nz, in_range, is_1bit, is_2bit, is_par;
    logic [CODE_W-1:0] corr_code;
    logic [DATA_W-1:0] data_x;
    logic              s2_load, xfer;

    for (genvar k = 0; k < R; k++) begin : g_syn
        assign syn_in[k] = ^(in_code & syn_mask(k));
    end
    assign par_in = ^{in_parity, in_code};

    assign syn_nz   = |s1_syn_q;
    assign in_range = (int'(s1_syn_q) <= CODE_W);
    assign is_1bit  = syn_nz & s1_par_q & in_range;
    assign is_2bit  = (syn_nz & ~s1_par_q) | ~in_range;
    assign is_par   = ~syn_nz & s1_par_q;

    // A single-bit error sits at code position S, i.e. bit S-1.
    assign corr_code = s1_code_q ^ (CODE_W'(is_1bit & s1_cen_q) << (s1_syn_q - R'(1)));

    for (genvar d = 0; d < DATA_W; d++) begin : g_extract
        assign data_x[d] = corr_code[data_pos(d) - 1];
    end

    assign s2_load  = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_load;
    assign xfer     = out_valid_q & out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s1_cen_d    = s1_cen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        err1_d      = err1_q;
        err2_d      = err2_q;
        errp_d      = errp_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            s1_code_d  = in_code;
            s1_syn_d   = syn_in;
            s1_par_d   = par_in;
            s1_cen_d   = correct_en;
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            out_data_d  = data_x;
            out_syn_d   = s1_syn_q;
            err1_d      = s1_valid_q & is_1bit;
            err2_d      = s1_valid_q & is_2bit;
            errp_d      = s1_valid_q & is_par;
        end

        // Clear has priority over a coincident increment.
        if (cnt_clear) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else begin
            if (xfer && err1_q && !(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
            if (xfer && err2_q && !(&cnt2_q)) cnt2_d = cnt2_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_cen_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            err1_q      <= 1'b0;
            err2_q      <= 1'b0;
            errp_q      <= 1'b0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s1_cen_q    <= s1_cen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            err1_q      <= err1_d;
            err2_q      <= err2_d;
            errp_q      <= errp_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_syndrome   = out_syn_q;
    assign out_err_1bit   = err1_q;
    assign out_err_2bit   = err2_q;
    assign out_err_parity = errp_q;
    assign cnt_1bit       = cnt1_q;
    assign cnt_2bit       = cnt2_q;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Bench for hamming_secded_dec_pipe: a DATA_W=4/CNT_W=2 instance and a DATA_W=8 instance,
// checked against an arithmetic SECDED encode/decode model.
module tb_hamming_secded_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       in_valid, in_ready, in_parity, correct_en, out_valid, out_ready, cnt_clear;
    logic [6:0] in_code;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic       e1, e2, ep;
    logic [1:0] cnt_1bit, cnt_2bit;

    logic        in_valid8, in_ready8, in_parity8, correct_en8, out_valid8, out_ready8, cnt_clear8;
    logic [11:0] in_code8;
    logic [7:0]  out_data8;
    logic [3:0]  out_syndrome8;
    logic        e1_8, e2_8, ep_8;
    logic [15:0] cnt_1bit8, cnt_2bit8;

    hamming_secded_dec_pipe #(.DATA_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .in_parity(in_parity), .correct_en(correct_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
        .out_err_1bit(e1), .out_err_2bit(e2), .out_err_parity(ep),
        .cnt_1bit(cnt_1bit), .cnt_2bit(cnt_2bit), .cnt_clear(cnt_clear)
    );

    hamming_secded_dec_pipe #(.DATA_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_code(in_code8),
        .in_parity(in_parity8), .correct_en(correct_en8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_data(out_data8), .out_syndrome(out_syndrome8),
        .out_err_1bit(e1_8), .out_err_2bit(e2_8), .out_err_parity(ep_8),
        .cnt_1bit(cnt_1bit8), .cnt_2bit(cnt_2bit8), .cnt_clear(cnt_clear8)
    );

    typedef struct {
        logic [63:0] data;
        int          syn;
        bit          f1, f2, fp;
    } res_t;

    typedef struct {
        logic [6:0] code;
        logic       par;
        logic       cen;
    } stim_t;

    function automatic int r_of(input int dw);
        int r;
        r = 0;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    // Check bits are chosen so that the XOR of all set positions is zero.
    function automatic logic [63:0] encode(input logic [63:0] data, input int dw);
        int cw, j, syn;
        logic [63:0] code;
        cw = dw + r_of(dw);
        code = '0;
        j = 0;
        syn = 0;
        for (int p = 1; p <= cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                code[p-1] = data[j];
                if (data[j]) syn = syn ^ p;
                j++;
            end
        end
        for (int k = 0; (1 << k) <= cw; k++) code[(1 << k) - 1] = syn[k];
        return code;
    endfunction

    function automatic res_t model(input logic [63:0] code_in, input logic par, input logic cen,
                                   input int dw);
        res_t r;
        int cw, j, syn;
        bit odd;
        logic [63:0] code;
        code = code_in;
        cw = dw + r_of(dw);
        syn = 0;
        odd = par;
        for (int p = 1; p <= cw; p++) begin
            if (code[p-1]) begin
                syn = syn ^ p;
                odd = !odd;
            end
        end
        r.syn = syn;
        r.f1 = (syn != 0) && odd && (syn <= cw);
        r.f2 = ((syn != 0) && !odd) || (syn > cw);
        r.fp = (syn == 0) && odd;
        if (r.f1 && cen) code[syn-1] = !code[syn-1];
        r.data = '0;
        j = 0;
        for (int p = 1; p <= cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.data[j] = code[p-1];
                j++;
            end
        end
        return r;
    endfunction

    function automatic stim_t rand_stim4();
        stim_t s;
        logic [63:0] c;
        int kind, a, b;
        c = encode(64'($urandom_range(0, 15)), 4);
        kind = $urandom_range(0, 3);
        a = $urandom_range(0, 6);
        b = (a + $urandom_range(1, 6)) % 7;
        s.par = ^c[6:0];
        if (kind == 1 || kind == 2) c[a] = !c[a];
        if (kind == 2) c[b] = !c[b];
        if (kind == 3) s.par = !s.par;
        s.code = c[6:0];
        s.cen = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic issue4(input logic [6:0] c, input logic p, input logic cen);
        in_valid = 1'b1;
        in_code = c;
        in_parity = p;
        correct_en = cen;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [11:0] c, input logic p, input logic cen);
        in_valid8 = 1'b1;
        in_code8 = c;
        in_parity8 = p;
        correct_en8 = cen;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep, cnt_1bit, cnt_2bit} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_state4: got %h required 0",
                     {out_valid, out_data, out_syndrome, e1, e2, ep, cnt_1bit, cnt_2bit});
        end
        n_checks++;
        if ({out_valid8, out_data8, out_syndrome8, e1_8, e2_8, ep_8, cnt_1bit8, cnt_2bit8} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_state8: got %h required 0",
                     {out_valid8, out_data8, out_syndrome8, e1_8, e2_8, ep_8, cnt_1bit8, cnt_2bit8});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, in_ready8} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 11", {in_ready, in_ready8});
        end
    endtask

    task automatic test_clean();
        issue4(7'h55, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== {1'b1, 4'hB, 3'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL clean_word: got v=%b d=%h s=%0d f=%b%b%b required v=1 d=b s=0 f=000",
                     out_valid, out_data, out_syndrome, e1, e2, ep);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, cnt_1bit, cnt_2bit} !== 5'b0) begin
            n_fail++;
            $display("FAIL clean_counters: got v=%b c1=%0d c2=%0d required 0 0 0",
                     out_valid, cnt_1bit, cnt_2bit);
        end
    endtask

    task automatic test_single();
        issue4(7'h45, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== {1'b1, 4'hB, 3'd5, 3'b100}) begin
            n_fail++;
            $display("FAIL single_corrected: got d=%h s=%0d f=%b%b%b required d=b s=5 f=100",
                     out_data, out_syndrome, e1, e2, ep);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cnt_1bit !== 2'd1) begin
            n_fail++;
            $display("FAIL single_cnt: got %0d required 1", cnt_1bit);
        end
        issue4(7'h45, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== {1'b1, 4'h9, 3'd5, 3'b100}) begin
            n_fail++;
            $display("FAIL single_detect_only: got d=%h s=%0d f=%b%b%b required d=9 s=5 f=100",
                     out_data, out_syndrome, e1, e2, ep);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_double_parity();
        issue4(7'h56, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== {1'b1, 4'hB, 3'd3, 3'b010}) begin
            n_fail++;
            $display("FAIL double_err: got d=%h s=%0d f=%b%b%b required d=b s=3 f=010",
                     out_data, out_syndrome, e1, e2, ep);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({cnt_1bit, cnt_2bit} !== {2'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL double_cnt: got c1=%0d c2=%0d required 2 1", cnt_1bit, cnt_2bit);
        end
        issue4(7'h55, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== {1'b1, 4'hB, 3'd0, 3'b001}) begin
            n_fail++;
            $display("FAIL parity_err: got d=%h s=%0d f=%b%b%b required d=b s=0 f=001",
                     out_data, out_syndrome, e1, e2, ep);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({cnt_1bit, cnt_2bit} !== {2'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL parity_cnt: got c1=%0d c2=%0d required 2 1", cnt_1bit, cnt_2bit);
        end
    endtask

    task automatic test_back_to_back();
        stim_t stim[8];
        res_t  expq[$];
        res_t  r;
        int    sent, got, occ, c1, c2;
        bit    prev_stall, in_fire, out_fire, exp_rdy;
        logic [10:0] held;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        for (int i = 0; i < 8; i++) stim[i] = rand_stim4();
        sent = 0; got = 0; occ = 0; c1 = 0; c2 = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            in_valid = (sent < 8) && ($urandom_range(0, 3) != 0);
            if (sent < 8) begin
                in_code = stim[sent].code;
                in_parity = stim[sent].par;
                correct_en = stim[sent].cen;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                n_checks++;
                if ({out_valid, out_data, out_syndrome, e1, e2, ep} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h required %h",
                             {out_valid, out_data, out_syndrome, e1, e2, ep}, held);
                end
            end
            exp_rdy = (occ < 2) || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_in_ready: got %b required %b (occupancy %0d)", in_ready, exp_rdy, occ);
            end
            out_fire = out_valid && out_ready;
            in_fire = in_valid && in_ready;
            if (out_fire) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_output: got d=%h with nothing outstanding", out_data);
                end else begin
                    r = expq.pop_front();
                    if ({out_data, out_syndrome, e1, e2, ep} !== {r.data[3:0], r.syn[2:0], r.f1, r.f2, r.fp}) begin
                        n_fail++;
                        $display("FAIL bp_word%0d: got d=%h s=%0d f=%b%b%b required d=%h s=%0d f=%b%b%b",
                                 got, out_data, out_syndrome, e1, e2, ep,
                                 r.data[3:0], r.syn, r.f1, r.f2, r.fp);
                    end
                    if (r.f1 && c1 < 3) c1++;
                    if (r.f2 && c2 < 3) c2++;
                end
                got++;
            end
            if (in_fire) begin
                expq.push_back(model(64'(stim[sent].code), stim[sent].par, stim[sent].cen, 4));
                sent++;
            end
            occ = occ + int'(in_fire) - int'(out_fire);
            prev_stall = out_valid && !out_ready;
            held = {out_valid, out_data, out_syndrome, e1, e2, ep};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 8 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL bp_complete: got %0d words (%0d pending) required 8 (0)", got, expq.size());
        end
        n_checks++;
        if ({cnt_1bit, cnt_2bit} !== {2'(c1), 2'(c2)}) begin
            n_fail++;
            $display("FAIL bp_counters: got c1=%0d c2=%0d required %0d %0d", cnt_1bit, cnt_2bit, c1, c2);
        end
    endtask

    task automatic test_saturation();
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue4(7'h45, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_checks++;
        if ({cnt_1bit, cnt_2bit} !== {2'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL saturate: got c1=%0d c2=%0d required 3 0", cnt_1bit, cnt_2bit);
        end
        issue4(7'h45, 1'b0, 1'b1);
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        n_checks++;
        if ({out_valid, e1} !== 2'b11) begin
            n_fail++;
            $display("FAIL clear_setup: got v=%b e1=%b required 1 1", out_valid, e1);
        end
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        n_checks++;
        if (cnt_1bit !== 2'd0) begin
            n_fail++;
            $display("FAIL clear_wins: got %0d required 0", cnt_1bit);
        end
    endtask

    task automatic test_reset_midstream();
        issue4(7'h56, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (cnt_2bit !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_cnt: got %0d required 1", cnt_2bit);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 7'h55; in_parity = 1'b0; correct_en = 1'b1;
        @(posedge clk); #1;
        in_code = 7'h45;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_stall: got v=%b rdy=%b required 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_data, out_syndrome, e1, e2, ep, cnt_1bit, cnt_2bit} !== 15'h0) begin
            n_fail++;
            $display("FAIL midstream_reset: got %h required 0",
                     {out_valid, out_data, out_syndrome, e1, e2, ep, cnt_1bit, cnt_2bit});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b required 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ghost_word: got out_valid=%b required 0 (cycle %0d)", out_valid, i);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_out_of_range(inout int c2_model);
        logic [63:0] c;
        logic [7:0]  d;
        logic        p;
        d = 8'($urandom_range(0, 255));
        c = encode(64'(d), 8);
        p = ^c[11:0];
        c[0] = !c[0]; c[3] = !c[3]; c[7] = !c[7];
        issue8(c[11:0], p, 1'b1);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid8, out_data8, out_syndrome8, e1_8, e2_8, ep_8} !== {1'b1, d, 4'd13, 3'b010}) begin
            n_fail++;
            $display("FAIL out_of_range: got d=%h s=%0d f=%b%b%b required d=%h s=13 f=010",
                     out_data8, out_syndrome8, e1_8, e2_8, ep_8, d);
        end
        c2_model++;
        @(posedge clk); #1;
        n_checks++;
        if (cnt_2bit8 !== 16'(c2_model)) begin
            n_fail++;
            $display("FAIL out_of_range_cnt: got %0d required %0d", cnt_2bit8, c2_model);
        end
    endtask

    task automatic test_random8(inout int c2_model);
        logic [63:0] c;
        logic        p, cen;
        res_t        r;
        int          c1_model, nflip;
        c1_model = 0;
        for (int i = 0; i < 12; i++) begin
            c = encode(64'($urandom_range(0, 255)), 8);
            p = ^c[11:0];
            nflip = $urandom_range(0, 3);
            for (int f = 0; f < nflip; f++) begin
                int b;
                b = $urandom_range(0, 12);
                if (b == 12) p = !p;
                else c[b] = !c[b];
            end
            cen = 1'($urandom_range(0, 1));
            r = model(c, p, cen, 8);
            issue8(c[11:0], p, cen);
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid8, out_data8, out_syndrome8, e1_8, e2_8, ep_8} !==
                {1'b1, r.data[7:0], r.syn[3:0], r.f1, r.f2, r.fp}) begin
                n_fail++;
                $display("FAIL rand8_word%0d: got d=%h s=%0d f=%b%b%b required d=%h s=%0d f=%b%b%b",
                         i, out_data8, out_syndrome8, e1_8, e2_8, ep_8,
                         r.data[7:0], r.syn, r.f1, r.f2, r.fp);
            end
            if (r.f1) c1_model++;
            if (r.f2) c2_model++;
        end
        @(posedge clk); #1;
        n_checks++;
        if ({cnt_1bit8, cnt_2bit8} !== {16'(c1_model), 16'(c2_model)}) begin
            n_fail++;
            $display("FAIL rand8_counters: got c1=%0d c2=%0d required %0d %0d",
                     cnt_1bit8, cnt_2bit8, c1_model, c2_model);
        end
    endtask

    initial begin
        int c2_8;
        c2_8 = 0;
        in_valid = 1'b0; in_code = '0; in_parity = 1'b0; correct_en = 1'b1;
        out_ready = 1'b1; cnt_clear = 1'b0;
        in_valid8 = 1'b0; in_code8 = '0; in_parity8 = 1'b0; correct_en8 = 1'b1;
        out_ready8 = 1'b1; cnt_clear8 = 1'b0;
        test_reset();
        test_clean();
        test_single();
        test_double_parity();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        test_out_of_range(c2_8);
        test_random8(c2_8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
